// File: rtl/device_bus_arbiter.sv
// device_bus_arbiter: two-master (0=core, 1=Zynq) to one-slave AXI4-Lite
// arbiter. One transaction at a time, round-robin between masters.
// Ports: uncoreclk/uncore_aresetn; S0_AXI_*, S1_AXI_* slave ports facing
// the masters; M_AXI_* master port facing the device bus.
module device_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    uncoreclk,
  input  logic                    uncore_aresetn,
  // master 0 (core)
  input  logic [ADDR_WIDTH-1:0]   S0_AXI_awaddr,
  input  logic                    S0_AXI_awvalid,
  output logic                    S0_AXI_awready,
  input  logic [DATA_WIDTH-1:0]   S0_AXI_wdata,
  input  logic [DATA_WIDTH/8-1:0] S0_AXI_wstrb,
  input  logic                    S0_AXI_wvalid,
  output logic                    S0_AXI_wready,
  output logic [1:0]              S0_AXI_bresp,
  output logic                    S0_AXI_bvalid,
  input  logic                    S0_AXI_bready,
  input  logic [ADDR_WIDTH-1:0]   S0_AXI_araddr,
  input  logic                    S0_AXI_arvalid,
  output logic                    S0_AXI_arready,
  output logic [DATA_WIDTH-1:0]   S0_AXI_rdata,
  output logic [1:0]              S0_AXI_rresp,
  output logic                    S0_AXI_rvalid,
  input  logic                    S0_AXI_rready,
  // master 1 (Zynq PS)
  input  logic [ADDR_WIDTH-1:0]   S1_AXI_awaddr,
  input  logic                    S1_AXI_awvalid,
  output logic                    S1_AXI_awready,
  input  logic [DATA_WIDTH-1:0]   S1_AXI_wdata,
  input  logic [DATA_WIDTH/8-1:0] S1_AXI_wstrb,
  input  logic                    S1_AXI_wvalid,
  output logic                    S1_AXI_wready,
  output logic [1:0]              S1_AXI_bresp,
  output logic                    S1_AXI_bvalid,
  input  logic                    S1_AXI_bready,
  input  logic [ADDR_WIDTH-1:0]   S1_AXI_araddr,
  input  logic                    S1_AXI_arvalid,
  output logic                    S1_AXI_arready,
  output logic [DATA_WIDTH-1:0]   S1_AXI_rdata,
  output logic [1:0]              S1_AXI_rresp,
  output logic                    S1_AXI_rvalid,
  input  logic                    S1_AXI_rready,
  // device bus
  output logic [ADDR_WIDTH-1:0]   M_AXI_awaddr,
  output logic                    M_AXI_awvalid,
  input  logic                    M_AXI_awready,
  output logic [DATA_WIDTH-1:0]   M_AXI_wdata,
  output logic [DATA_WIDTH/8-1:0] M_AXI_wstrb,
  output logic                    M_AXI_wvalid,
  input  logic                    M_AXI_wready,
  input  logic [1:0]              M_AXI_bresp,
  input  logic                    M_AXI_bvalid,
  output logic                    M_AXI_bready,
  output logic [ADDR_WIDTH-1:0]   M_AXI_araddr,
  output logic                    M_AXI_arvalid,
  input  logic                    M_AXI_arready,
  input  logic [DATA_WIDTH-1:0]   M_AXI_rdata,
  input  logic [1:0]              M_AXI_rresp,
  input  logic                    M_AXI_rvalid,
  output logic                    M_AXI_rready
);

  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE, W_REQ, W_RESP, B_OUT, R_REQ, R_RESP, R_OUT
  } state_e;

  state_e                  state_q, state_d;
  logic                    gnt_q, gnt_d;
  logic                    last_q, last_d;
  logic                    rw_last_q, rw_last_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]           wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [1:0]              bvalid_q, bvalid_d;
  logic [1:0]              rvalid_q, rvalid_d;

  logic [1:0] wreq, rreq, req;
  logic       sel, sel_w, sel_r, do_w;
  logic       grant, wgnt, rgnt;
  logic       s_bready, s_rready;
  logic       aw_done, w_done;

  assign wreq = {S1_AXI_awvalid & S1_AXI_wvalid,
                 S0_AXI_awvalid & S0_AXI_wvalid};
  assign rreq = {S1_AXI_arvalid, S0_AXI_arvalid};
  assign req  = wreq | rreq;

  // tie goes to the master that did not win last time
  assign sel   = (&req) ? ~last_q : req[1];
  assign sel_w = wreq[sel];
  assign sel_r = rreq[sel];
  // rw_last_q=1 means the last grant was a read
  assign do_w  = (sel_w & sel_r) ? rw_last_q : sel_w;

  // readies are gated by reset so they also drop asynchronously
  assign grant = (state_q == IDLE) & (|req) & uncore_aresetn;
  assign wgnt  = grant & do_w;
  assign rgnt  = grant & ~do_w;

  assign S0_AXI_awready = wgnt & ~sel;
  assign S0_AXI_wready  = wgnt & ~sel;
  assign S0_AXI_arready = rgnt & ~sel;
  assign S1_AXI_awready = wgnt & sel;
  assign S1_AXI_wready  = wgnt & sel;
  assign S1_AXI_arready = rgnt & sel;

  assign s_bready = gnt_q ? S1_AXI_bready : S0_AXI_bready;
  assign s_rready = gnt_q ? S1_AXI_rready : S0_AXI_rready;

  assign aw_done = ~awvalid_q | M_AXI_awready;
  assign w_done  = ~wvalid_q | M_AXI_wready;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    rw_last_d = rw_last_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          gnt_d     = sel;
          last_d    = sel;
          rw_last_d = ~do_w;
          if (do_w) begin
            state_d   = W_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = sel ? S1_AXI_awaddr : S0_AXI_awaddr;
            wdata_d   = sel ? S1_AXI_wdata : S0_AXI_wdata;
            wstrb_d   = sel ? S1_AXI_wstrb : S0_AXI_wstrb;
          end else begin
            state_d   = R_REQ;
            arvalid_d = 1'b1;
            araddr_d  = sel ? S1_AXI_araddr : S0_AXI_araddr;
          end
        end
      end
      W_REQ: begin
        // each valid drops on its own handshake
        awvalid_d = awvalid_q & ~M_AXI_awready;
        wvalid_d  = wvalid_q & ~M_AXI_wready;
        if (aw_done & w_done) begin
          state_d  = W_RESP;
          bready_d = 1'b1;
        end
      end
      W_RESP: begin
        if (M_AXI_bvalid) begin
          state_d  = B_OUT;
          bready_d = 1'b0;
          bresp_d  = M_AXI_bresp;
          bvalid_d = gnt_q ? 2'b10 : 2'b01;
        end
      end
      B_OUT: begin
        if (s_bready) begin
          state_d  = IDLE;
          bvalid_d = 2'b00;
        end
      end
      R_REQ: begin
        if (M_AXI_arready) begin
          state_d   = R_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      R_RESP: begin
        if (M_AXI_rvalid) begin
          state_d  = R_OUT;
          rready_d = 1'b0;
          rdata_d  = M_AXI_rdata;
          rresp_d  = M_AXI_rresp;
          rvalid_d = gnt_q ? 2'b10 : 2'b01;
        end
      end
      R_OUT: begin
        if (s_rready) begin
          state_d  = IDLE;
          rvalid_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge uncoreclk or negedge uncore_aresetn) begin
    if (!uncore_aresetn) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      rw_last_q <= 1'b1;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      bvalid_q  <= '0;
      rvalid_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      rw_last_q <= rw_last_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign M_AXI_awaddr  = awaddr_q;
  assign M_AXI_awvalid = awvalid_q;
  assign M_AXI_wdata   = wdata_q;
  assign M_AXI_wstrb   = wstrb_q;
  assign M_AXI_wvalid  = wvalid_q;
  assign M_AXI_bready  = bready_q;
  assign M_AXI_araddr  = araddr_q;
  assign M_AXI_arvalid = arvalid_q;
  assign M_AXI_rready  = rready_q;

  assign S0_AXI_bvalid = bvalid_q[0];
  assign S1_AXI_bvalid = bvalid_q[1];
  assign S0_AXI_bresp  = bresp_q;
  assign S1_AXI_bresp  = bresp_q;
  assign S0_AXI_rvalid = rvalid_q[0];
  assign S1_AXI_rvalid = rvalid_q[1];
  assign S0_AXI_rdata  = rdata_q;
  assign S1_AXI_rdata  = rdata_q;
  assign S0_AXI_rresp  = rresp_q;
  assign S1_AXI_rresp  = rresp_q;

endmodule

// File: tb/tb_device_bus_arbiter.sv
// tb_device_bus_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_device_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] S0_AXI_awaddr, S0_AXI_wdata, S0_AXI_araddr, S0_AXI_rdata;
  logic [3:0]  S0_AXI_wstrb;
  logic [1:0]  S0_AXI_bresp, S0_AXI_rresp;
  logic S0_AXI_awvalid, S0_AXI_awready, S0_AXI_wvalid, S0_AXI_wready;
  logic S0_AXI_bvalid, S0_AXI_bready, S0_AXI_arvalid, S0_AXI_arready;
  logic S0_AXI_rvalid, S0_AXI_rready;
  logic [31:0] S1_AXI_awaddr, S1_AXI_wdata, S1_AXI_araddr, S1_AXI_rdata;
  logic [3:0]  S1_AXI_wstrb;
  logic [1:0]  S1_AXI_bresp, S1_AXI_rresp;
  logic S1_AXI_awvalid, S1_AXI_awready, S1_AXI_wvalid, S1_AXI_wready;
  logic S1_AXI_bvalid, S1_AXI_bready, S1_AXI_arvalid, S1_AXI_arready;
  logic S1_AXI_rvalid, S1_AXI_rready;
  logic [31:0] M_AXI_awaddr, M_AXI_wdata, M_AXI_araddr, M_AXI_rdata;
  logic [3:0]  M_AXI_wstrb;
  logic [1:0]  M_AXI_bresp, M_AXI_rresp;
  logic M_AXI_awvalid, M_AXI_awready, M_AXI_wvalid, M_AXI_wready;
  logic M_AXI_bvalid, M_AXI_bready, M_AXI_arvalid, M_AXI_arready;
  logic M_AXI_rvalid, M_AXI_rready;

  device_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .uncoreclk(clk), .uncore_aresetn(rst_n),
    .S0_AXI_awaddr(S0_AXI_awaddr), .S0_AXI_awvalid(S0_AXI_awvalid),
    .S0_AXI_awready(S0_AXI_awready), .S0_AXI_wdata(S0_AXI_wdata),
    .S0_AXI_wstrb(S0_AXI_wstrb), .S0_AXI_wvalid(S0_AXI_wvalid),
    .S0_AXI_wready(S0_AXI_wready), .S0_AXI_bresp(S0_AXI_bresp),
    .S0_AXI_bvalid(S0_AXI_bvalid), .S0_AXI_bready(S0_AXI_bready),
    .S0_AXI_araddr(S0_AXI_araddr), .S0_AXI_arvalid(S0_AXI_arvalid),
    .S0_AXI_arready(S0_AXI_arready), .S0_AXI_rdata(S0_AXI_rdata),
    .S0_AXI_rresp(S0_AXI_rresp), .S0_AXI_rvalid(S0_AXI_rvalid),
    .S0_AXI_rready(S0_AXI_rready),
    .S1_AXI_awaddr(S1_AXI_awaddr), .S1_AXI_awvalid(S1_AXI_awvalid),
    .S1_AXI_awready(S1_AXI_awready), .S1_AXI_wdata(S1_AXI_wdata),
    .S1_AXI_wstrb(S1_AXI_wstrb), .S1_AXI_wvalid(S1_AXI_wvalid),
    .S1_AXI_wready(S1_AXI_wready), .S1_AXI_bresp(S1_AXI_bresp),
    .S1_AXI_bvalid(S1_AXI_bvalid), .S1_AXI_bready(S1_AXI_bready),
    .S1_AXI_araddr(S1_AXI_araddr), .S1_AXI_arvalid(S1_AXI_arvalid),
    .S1_AXI_arready(S1_AXI_arready), .S1_AXI_rdata(S1_AXI_rdata),
    .S1_AXI_rresp(S1_AXI_rresp), .S1_AXI_rvalid(S1_AXI_rvalid),
    .S1_AXI_rready(S1_AXI_rready),
    .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awvalid(M_AXI_awvalid),
    .M_AXI_awready(M_AXI_awready), .M_AXI_wdata(M_AXI_wdata),
    .M_AXI_wstrb(M_AXI_wstrb), .M_AXI_wvalid(M_AXI_wvalid),
    .M_AXI_wready(M_AXI_wready), .M_AXI_bresp(M_AXI_bresp),
    .M_AXI_bvalid(M_AXI_bvalid), .M_AXI_bready(M_AXI_bready),
    .M_AXI_araddr(M_AXI_araddr), .M_AXI_arvalid(M_AXI_arvalid),
    .M_AXI_arready(M_AXI_arready), .M_AXI_rdata(M_AXI_rdata),
    .M_AXI_rresp(M_AXI_rresp), .M_AXI_rvalid(M_AXI_rvalid),
    .M_AXI_rready(M_AXI_rready)
  );

  // device-bus slave: directed mode answers from an address map
  logic        rnd_mode;
  logic [31:0] rnd_rdata;
  logic [1:0]  rnd_rresp;

  function automatic logic [31:0] map_rdata(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h1111;
      32'h20:  return 32'h2222;
      32'h30:  return 32'h3333;
      default: return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  function automatic logic [1:0] map_rresp(input logic [31:0] a);
    case (a)
      32'h20:  return 2'b01;
      32'h30:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  assign M_AXI_rdata = rnd_mode ? rnd_rdata : map_rdata(M_AXI_araddr);
  assign M_AXI_rresp = rnd_mode ? rnd_rresp : map_rresp(M_AXI_araddr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [95:0] obs,
                     input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic coin();
    logic [31:0] r;
    r = $urandom;
    return r[0];
  endfunction

  task automatic idle_inputs();
    S0_AXI_awaddr = '0; S0_AXI_wdata = '0; S0_AXI_wstrb = '0;
    S0_AXI_araddr = '0; S0_AXI_awvalid = 0; S0_AXI_wvalid = 0;
    S0_AXI_arvalid = 0; S0_AXI_bready = 0; S0_AXI_rready = 0;
    S1_AXI_awaddr = '0; S1_AXI_wdata = '0; S1_AXI_wstrb = '0;
    S1_AXI_araddr = '0; S1_AXI_awvalid = 0; S1_AXI_wvalid = 0;
    S1_AXI_arvalid = 0; S1_AXI_bready = 0; S1_AXI_rready = 0;
    M_AXI_awready = 1; M_AXI_wready = 1; M_AXI_arready = 1;
    M_AXI_bvalid = 1; M_AXI_bresp = 2'b00; M_AXI_rvalid = 1;
    rnd_mode = 0; rnd_rdata = '0; rnd_rresp = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  logic [10:0] all_vr;
  assign all_vr = {M_AXI_awvalid, M_AXI_wvalid, M_AXI_arvalid,
                   M_AXI_bready, M_AXI_rready, S0_AXI_bvalid,
                   S0_AXI_rvalid, S1_AXI_bvalid, S1_AXI_rvalid,
                   S0_AXI_awready | S0_AXI_wready | S0_AXI_arready,
                   S1_AXI_awready | S1_AXI_wready | S1_AXI_arready};

  logic [5:0] rdy6;
  assign rdy6 = {S1_AXI_awready, S1_AXI_wready, S1_AXI_arready,
                 S0_AXI_awready, S0_AXI_wready, S0_AXI_arready};

  logic got;
  int   gcyc, nb0, nb1;

  // transaction-level model state for the random phase
  logic        pw[2], pr[2];
  logic [31:0] wa[2], wd[2], ra[2];
  logic [3:0]  ws[2];
  logic        m_last, m_rdlast, busy, tm, tw, mw;
  logic        q0, q1;
  logic [31:0] taddr, tdata, erdata;
  logic [3:0]  tstrb;
  logic [1:0]  eresp;
  logic [5:0]  exp6;
  int          awh, wh, arh, age, ntx;
  logic [31:0] r32;

  initial begin
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    // requests during reset must not be granted
    S0_AXI_awvalid = 1; S0_AXI_wvalid = 1; S1_AXI_arvalid = 1;
    #1;
    chk("rst_vr", all_vr, 0);
    chk("rst_data", {M_AXI_awaddr, M_AXI_wdata, M_AXI_araddr}, 0);
    chk("rst_resp", {S0_AXI_rdata, S0_AXI_bresp, S0_AXI_rresp}, 0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1;

    // lone awvalid is not a request
    @(negedge clk);
    S0_AXI_awvalid = 1; #1;
    chk("lone_aw", {S0_AXI_awready, S0_AXI_wready}, 2'b00);
    @(negedge clk); #1;
    chk("lone_aw_m", M_AXI_awvalid, 0);
    S0_AXI_awvalid = 0;

    // single write from S0
    @(negedge clk);
    S0_AXI_awaddr = 32'h4000_0008; S0_AXI_wdata = 32'hDEAD_BEEF;
    S0_AXI_wstrb = 4'hF; S0_AXI_awvalid = 1; S0_AXI_wvalid = 1;
    S0_AXI_bready = 1; #1;
    chk("w1_grant", {S0_AXI_awready, S0_AXI_wready, S0_AXI_arready}, 3'b110);
    chk("w1_s1", {S1_AXI_awready, S1_AXI_wready, S1_AXI_arready}, 0);
    @(negedge clk);
    S0_AXI_awvalid = 0; S0_AXI_wvalid = 0; #1;
    chk("w1_m", {M_AXI_awvalid, M_AXI_wvalid, M_AXI_awaddr, M_AXI_wdata},
        {2'b11, 32'h4000_0008, 32'hDEAD_BEEF});
    chk("w1_strb", M_AXI_wstrb, 4'hF);
    @(negedge clk); #1;
    chk("w1_bready", {M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready}, 3'b001);
    @(negedge clk); #1;
    chk("w1_bvalid", {S0_AXI_bvalid, S0_AXI_bresp, S1_AXI_bvalid}, 4'b1000);
    @(negedge clk); #1;
    chk("w1_done", S0_AXI_bvalid, 0);

    // simultaneous reads after reset: S0 first
    do_reset();
    @(negedge clk);
    S0_AXI_araddr = 32'h10; S1_AXI_araddr = 32'h20;
    S0_AXI_arvalid = 1; S1_AXI_arvalid = 1;
    S0_AXI_rready = 1; S1_AXI_rready = 1; #1;
    chk("r2_tie", {S1_AXI_arready, S0_AXI_arready}, 2'b01);
    @(negedge clk);
    S0_AXI_arvalid = 0; #1;
    chk("r2_busy", S1_AXI_arready, 0);
    chk("r2_maddr", {M_AXI_arvalid, M_AXI_araddr}, {1'b1, 32'h10});
    got = 0;
    for (int i = 0; i < 10; i++)
      if (!got) begin @(negedge clk); #1; got = S0_AXI_rvalid; end
    chk("r2_s0_rvalid", got, 1);
    chk("r2_s0_rdata", {S0_AXI_rdata, S0_AXI_rresp, S1_AXI_rvalid},
        {32'h1111, 2'b00, 1'b0});
    got = 0;
    for (int i = 0; i < 10; i++)
      if (!got) begin @(negedge clk); #1; got = S1_AXI_arready; end
    chk("r2_s1_grant", got, 1);
    @(negedge clk);
    S1_AXI_arvalid = 0;
    got = 0;
    for (int i = 0; i < 10; i++)
      if (!got) begin @(negedge clk); #1; got = S1_AXI_rvalid; end
    chk("r2_s1_rvalid", got, 1);
    chk("r2_s1_rdata", {S1_AXI_rdata, S1_AXI_rresp, S0_AXI_rvalid},
        {32'h2222, 2'b01, 1'b0});

    // S0 holds write and read: directions alternate every 4 cycles
    @(negedge clk);
    S0_AXI_awaddr = 32'h100; S0_AXI_wdata = 32'h55; S0_AXI_wstrb = 4'h1;
    S0_AXI_araddr = 32'h104; S0_AXI_awvalid = 1; S0_AXI_wvalid = 1;
    S0_AXI_arvalid = 1; S0_AXI_bready = 1; S0_AXI_rready = 1;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int i = 0; i < 12; i++)
        if (!got) begin
          #1;
          got = S0_AXI_awready | S0_AXI_arready;
          if (!got) @(negedge clk);
        end
      chk("alt_grant", got, 1);
      chk("alt_dir", {S0_AXI_awready, S0_AXI_arready},
          (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k > 0) chk("alt_period", cyc - gcyc, 4);
      gcyc = cyc;
      @(negedge clk);
    end
    S0_AXI_awvalid = 0; S0_AXI_wvalid = 0; S0_AXI_arvalid = 0;
    repeat (6) @(negedge clk);

    // M_awready arrives 3 cycles after M_wready
    M_AXI_awready = 0;
    S1_AXI_awaddr = 32'h4000_0010; S1_AXI_wdata = 32'h1234_5678;
    S1_AXI_wstrb = 4'h3; S1_AXI_awvalid = 1; S1_AXI_wvalid = 1;
    S1_AXI_bready = 1; #1;
    chk("w4_grant", {S1_AXI_awready, S1_AXI_wready}, 2'b11);
    @(negedge clk);
    S1_AXI_awvalid = 0; S1_AXI_wvalid = 0; #1;
    chk("w4_t1", {M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready}, 3'b110);
    @(negedge clk); #1;
    chk("w4_t2", {M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready}, 3'b100);
    @(negedge clk); #1;
    chk("w4_t3", {M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready}, 3'b100);
    @(negedge clk);
    M_AXI_awready = 1; #1;
    chk("w4_t4", {M_AXI_awvalid, M_AXI_awaddr}, {1'b1, 32'h4000_0010});
    @(negedge clk); #1;
    chk("w4_t5", {M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready}, 3'b001);
    nb0 = 0; nb1 = 0;
    repeat (6) begin
      @(negedge clk); #1;
      nb0 += int'(S0_AXI_bvalid); nb1 += int'(S1_AXI_bvalid);
    end
    chk("w4_one_b", {nb1, nb0}, {32'd1, 32'd0});

    // read backpressure with rresp=2; pending S0 write must wait
    @(negedge clk);
    S1_AXI_araddr = 32'h30; S1_AXI_arvalid = 1; S1_AXI_rready = 0; #1;
    chk("r5_grant", S1_AXI_arready, 1);
    @(negedge clk);
    S1_AXI_arvalid = 0;
    S0_AXI_awaddr = 32'h200; S0_AXI_wdata = 32'hCAFE; S0_AXI_wstrb = 4'hF;
    S0_AXI_awvalid = 1; S0_AXI_wvalid = 1; S0_AXI_bready = 1;
    got = 0;
    for (int i = 0; i < 10; i++)
      if (!got) begin @(negedge clk); #1; got = S1_AXI_rvalid; end
    chk("r5_rvalid", got, 1);
    for (int j = 0; j < 5; j++) begin
      chk("r5_hold", {S1_AXI_rvalid, S1_AXI_rdata, S1_AXI_rresp},
          {1'b1, 32'h3333, 2'b10});
      chk("r5_nogrant", S0_AXI_awready, 0);
      if (j < 4) begin @(negedge clk); #1; end
    end
    S1_AXI_rready = 1;
    @(negedge clk); #1;
    chk("r5_release", {S1_AXI_rvalid, S0_AXI_awready}, 2'b01);
    @(negedge clk);
    S0_AXI_awvalid = 0; S0_AXI_wvalid = 0;
    repeat (6) @(negedge clk);

    // reset in W_RESP abandons the write
    M_AXI_bvalid = 0;
    S0_AXI_awaddr = 32'h300; S0_AXI_wdata = 32'h77;
    S0_AXI_awvalid = 1; S0_AXI_wvalid = 1; S0_AXI_bready = 1;
    @(negedge clk);
    S0_AXI_awvalid = 0; S0_AXI_wvalid = 0;
    got = 0;
    for (int i = 0; i < 10; i++)
      if (!got) begin @(negedge clk); #1; got = M_AXI_bready; end
    chk("w6_wresp", got, 1);
    rst_n = 0; #1;
    chk("w6_rst_vr", all_vr, 0);
    chk("w6_rst_data", {M_AXI_awaddr, M_AXI_wdata}, 0);
    @(negedge clk);
    rst_n = 1; M_AXI_bvalid = 1;
    @(negedge clk);
    S1_AXI_araddr = 32'h20; S1_AXI_arvalid = 1; S1_AXI_rready = 1; #1;
    chk("w6_s1_grant", S1_AXI_arready, 1);
    @(negedge clk);
    S1_AXI_arvalid = 0;
    got = 0;
    for (int i = 0; i < 10; i++)
      if (!got) begin @(negedge clk); #1; got = S1_AXI_rvalid; end
    chk("w6_s1_rvalid", got, 1);
    chk("w6_s1_rdata", {S1_AXI_rdata, S1_AXI_rresp, S0_AXI_bvalid},
        {32'h2222, 2'b01, 1'b0});

    // random traffic against a transaction-level model
    do_reset();
    rnd_mode = 1;
    m_last = 1; m_rdlast = 1; busy = 0; ntx = 0;
    tm = 0; tw = 0; taddr = '0; tdata = '0; tstrb = '0;
    eresp = '0; erdata = '0; awh = 0; wh = 0; arh = 0; age = 0;
    for (int n = 0; n < 2; n++) begin pw[n] = 0; pr[n] = 0; end
    @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pw[n] && $urandom_range(3) == 0) begin
          pw[n] = 1; wa[n] = $urandom; wd[n] = $urandom;
          r32 = $urandom; ws[n] = r32[3:0];
        end
        if (!pr[n] && $urandom_range(3) == 0) begin
          pr[n] = 1; ra[n] = $urandom;
        end
      end
      S0_AXI_awvalid = pw[0]; S0_AXI_wvalid = pw[0];
      S0_AXI_awaddr = wa[0]; S0_AXI_wdata = wd[0]; S0_AXI_wstrb = ws[0];
      S0_AXI_arvalid = pr[0]; S0_AXI_araddr = ra[0];
      S1_AXI_awvalid = pw[1]; S1_AXI_wvalid = pw[1];
      S1_AXI_awaddr = wa[1]; S1_AXI_wdata = wd[1]; S1_AXI_wstrb = ws[1];
      S1_AXI_arvalid = pr[1]; S1_AXI_araddr = ra[1];
      S0_AXI_bready = coin(); S0_AXI_rready = coin();
      S1_AXI_bready = coin(); S1_AXI_rready = coin();
      M_AXI_awready = coin(); M_AXI_wready = coin();
      M_AXI_arready = coin(); M_AXI_bvalid = coin();
      M_AXI_rvalid = coin();
      r32 = $urandom; M_AXI_bresp = r32[1:0]; rnd_rresp = r32[3:2];
      rnd_rdata = $urandom;
      #1;
      if (!busy) begin
        q0 = pw[0] | pr[0];
        q1 = pw[1] | pr[1];
        exp6 = '0;
        if (q0 | q1) begin
          tm = (q0 & q1) ? ~m_last : q1;
          mw = (pw[tm] & pr[tm]) ? m_rdlast : pw[tm];
          exp6 = mw ? 6'b110000 : 6'b001000;
          if (!tm) exp6 = exp6 >> 3;
        end
        chk("rnd_ready", rdy6, exp6);
        if (q0 | q1) begin
          busy = 1; tw = mw; age = 0;
          awh = 0; wh = 0; arh = 0;
          taddr = mw ? wa[tm] : ra[tm];
          tdata = wd[tm]; tstrb = ws[tm];
          if (mw) pw[tm] = 0; else pr[tm] = 0;
          m_last = tm; m_rdlast = ~mw;
        end
      end else begin
        chk("rnd_busy_ready", rdy6, 0);
        age++;
        if (tw) begin
          if (M_AXI_awvalid) chk("rnd_awaddr", M_AXI_awaddr, taddr);
          if (M_AXI_wvalid)
            chk("rnd_wdata", {M_AXI_wdata, M_AXI_wstrb}, {tdata, tstrb});
          if (M_AXI_awvalid & M_AXI_awready) awh++;
          if (M_AXI_wvalid & M_AXI_wready) wh++;
          if (M_AXI_bready & M_AXI_bvalid) eresp = M_AXI_bresp;
          chk("rnd_b_other", tm ? S0_AXI_bvalid : S1_AXI_bvalid, 0);
          if (tm ? S1_AXI_bvalid : S0_AXI_bvalid) begin
            chk("rnd_bresp", tm ? S1_AXI_bresp : S0_AXI_bresp, eresp);
            chk("rnd_hs_once", {awh, wh}, {32'd1, 32'd1});
            if (tm ? S1_AXI_bready : S0_AXI_bready) begin
              busy = 0; ntx++;
            end
          end
        end else begin
          if (M_AXI_arvalid) chk("rnd_araddr", M_AXI_araddr, taddr);
          if (M_AXI_arvalid & M_AXI_arready) arh++;
          if (M_AXI_rready & M_AXI_rvalid) begin
            erdata = M_AXI_rdata; eresp = M_AXI_rresp;
          end
          chk("rnd_r_other", tm ? S0_AXI_rvalid : S1_AXI_rvalid, 0);
          if (tm ? S1_AXI_rvalid : S0_AXI_rvalid) begin
            chk("rnd_rdata", tm ? {S1_AXI_rdata, S1_AXI_rresp}
                                : {S0_AXI_rdata, S0_AXI_rresp},
                {erdata, eresp});
            chk("rnd_ar_once", arh, 1);
            if (tm ? S1_AXI_rready : S0_AXI_rready) begin
              busy = 0; ntx++;
            end
          end
        end
        if (age > 200) begin
          chk("rnd_stall", age, 0);
          busy = 0;
        end
      end
      @(negedge clk);
    end
    chk("rnd_progress", ntx > 50, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
